uart_job_rx: RTL

- Consumes the byte stream from the UART receiver (`received`/`rx_byte`/`recv_error`) and assembles fixed-length job frames for the K12 hash core.
- Frame format: SYNC byte, then PAYLOAD_BYTES payload bytes, then an XOR checksum byte.
- A validated payload is presented as one wide word on a valid/ready handshake.
- Sits between the UART and the miner job-register stage.

---
 rtl/uart_job_pkg.sv | 30 +++
 rtl/uart_job_timeout.sv | 40 ++++
 rtl/uart_job_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_job_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_job_pkg
// Description : Shared types and constants for the UART job-frame receiver.
//               FSM state encoding, abort cause codes, ACK/NAK reply bytes
//               and the default frame start marker.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_job_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  // Abort cause reported on err_code
  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LINE    = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  // Reply bytes sent back over the UART when acknowledgements are enabled
  localparam logic [7:0] ACK_CODE = 8'h06;
  localparam logic [7:0] NAK_CODE = 8'h15;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_job_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_job_timeout
// Description : Inter-byte watchdog. Counts clk cycles while enabled; the
//               count is held at zero when disabled or cleared. expire_o is
//               high for the cycle in which the count equals
//               TIMEOUT_CYCLES-1 (the owner aborts and disables it then).
// Ports       : clk, rst_n   - clock, async active-low reset
//               enable_i     - count while high (frame in progress)
//               clear_i      - restart the count (byte received)
//               expire_o     - watchdog limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_job_timeout #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [23:0] cnt_q;

  assign expire_o = enable_i && !clear_i && (cnt_q == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 24'd0;
    end else if (!enable_i || clear_i) begin
      cnt_q <= 24'd0;
    end else if (!expire_o) begin
      // Stop at the limit so the counter can never wrap
      cnt_q <= cnt_q + 24'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_job_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_job_rx
// Description : Assembles SYNC + PAYLOAD_BYTES + XOR-checksum frames from the
//               UART byte stream and publishes validated payloads as one wide
//               word on a valid/ready handshake.
// Ports       : clk, rst_n            - clock, async active-low reset
//               rx_strobe/rx_data     - received byte pulse and value
//               rx_err                - UART line error pulse
//               job_data/job_valid    - published payload (byte 0 in LSBs)
//               job_ready             - consumer accept
//               frame_err/err_code    - abort pulse and last abort cause
//               busy                  - frame in progress
// Option      : UART_JOB_RX_ACK_EN adds ack_transmit/ack_byte/ack_busy and a
//               1-entry ACK/NAK reply queue.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_job_rx
  import uart_job_pkg::*;
#(
  parameter int          PAYLOAD_BYTES  = 84,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_strobe,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_err,
  output logic [PAYLOAD_BYTES*8-1:0] job_data,
  output logic                       job_valid,
  input  logic                       job_ready,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
`ifdef UART_JOB_RX_ACK_EN
  output logic                       ack_transmit,
  output logic [7:0]                 ack_byte,
  input  logic                       ack_busy,
`endif
  output logic                       busy
);

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  state_t                     state_q;
  logic [7:0]                 idx_q;
  logic [7:0]                 csum_q;
  logic [PAYLOAD_BYTES*8-1:0] shadow_q;
  logic [PAYLOAD_BYTES*8-1:0] job_data_q;
  logic                       job_valid_q;
  logic                       frame_err_q;
  logic [1:0]                 err_code_q;

  logic       expire_d;
  logic       abort_d;
  logic [1:0] abort_code_d;
  logic       publish_d;

  uart_job_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (state_q != HUNT),
    .clear_i  (rx_strobe),
    .expire_o (expire_d)
  );

  // Event decode with priority rx_err > rx_strobe > timeout; HUNT ignores
  // line errors and never times out.
  always_comb begin
    abort_d      = 1'b0;
    abort_code_d = ERR_CSUM;
    publish_d    = 1'b0;
    if (state_q != HUNT) begin
      if (rx_err) begin
        abort_d      = 1'b1;
        abort_code_d = ERR_LINE;
      end else if (rx_strobe) begin
        if (state_q == CHECK) begin
          if (rx_data != csum_q) begin
            abort_d      = 1'b1;
            abort_code_d = ERR_CSUM;
          end else if (job_valid_q && !job_ready) begin
            // Consumer still holds the previous job: drop the new one
            abort_d      = 1'b1;
            abort_code_d = ERR_OVF;
          end else begin
            publish_d = 1'b1;
          end
        end
      end else if (expire_d) begin
        abort_d      = 1'b1;
        abort_code_d = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      idx_q       <= 8'd0;
      csum_q      <= 8'd0;
      shadow_q    <= '0;
      job_data_q  <= '0;
      job_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_CSUM;
    end else begin
      frame_err_q <= 1'b0;
      if (job_valid_q && job_ready) job_valid_q <= 1'b0;

      if (abort_d) begin
        // Shadow register is intentionally left as is
        state_q     <= HUNT;
        idx_q       <= 8'd0;
        csum_q      <= 8'd0;
        frame_err_q <= 1'b1;
        err_code_q  <= abort_code_d;
      end else begin
        case (state_q)
          HUNT: begin
            if (rx_strobe && rx_data == SYNC_BYTE) begin
              state_q <= PAYLOAD;
              idx_q   <= 8'd0;
              csum_q  <= 8'd0;
            end
          end
          PAYLOAD: begin
            if (rx_strobe) begin
              shadow_q[8*idx_q +: 8] <= rx_data;
              csum_q                 <= csum_q ^ rx_data;
              idx_q                  <= idx_q + 8'd1;
              if (idx_q == LAST_IDX) state_q <= CHECK;
            end
          end
          CHECK: begin
            if (publish_d) begin
              job_data_q  <= shadow_q;
              job_valid_q <= 1'b1;
              state_q     <= HUNT;
              idx_q       <= 8'd0;
              csum_q      <= 8'd0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign job_data  = job_data_q;
  assign job_valid = job_valid_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != HUNT);

`ifdef UART_JOB_RX_ACK_EN
  logic       ack_pend_q;
  logic [7:0] ack_pend_code_q;
  logic       ack_transmit_q;
  logic [7:0] ack_byte_q;

  // Every abort here happens inside a frame, so all of them reply NAK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend_q      <= 1'b0;
      ack_pend_code_q <= 8'd0;
      ack_transmit_q  <= 1'b0;
      ack_byte_q      <= 8'd0;
    end else begin
      ack_transmit_q <= 1'b0;
      if (ack_pend_q && !ack_busy) begin
        ack_transmit_q <= 1'b1;
        ack_byte_q     <= ack_pend_code_q;
        ack_pend_q     <= 1'b0;
      end
      // A newer event replaces whatever is still waiting
      if (publish_d || abort_d) begin
        ack_pend_q      <= 1'b1;
        ack_pend_code_q <= publish_d ? ACK_CODE : NAK_CODE;
      end
    end
  end

  assign ack_transmit = ack_transmit_q;
  assign ack_byte     = ack_byte_q;
`endif

endmodule
`default_nettype wire
